// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROG,
    TEST,
    CHECK,
    DONE
  } state_t;

  // Extra shifts past the chain length so the test pulse can be seen leaving the tail.
  localparam int TEST_EXTRA_SHIFTS = 3;
  localparam int ERR_CNT_W         = 8;

  // Number of meaningful bits carried by the final bitstream word.
  function automatic int last_word_bits(input int size, input int width);
    return ((size % width) == 0) ? width : (size % width);
  endfunction

endpackage

// File: rtl/ccff_tail_checker.sv
// Compares ccff_tail against the expected pulse position during the chain test
// and keeps a saturating count of mismatches.
module ccff_tail_checker
  import ccff_loader_pkg::*;
#(
  parameter int BITSTREAM_SIZE = 1024,
  parameter int CNT_W          = $clog2(BITSTREAM_SIZE + 4)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 check_en,
  input  logic [CNT_W-1:0]     pulse_idx,
  input  logic                 ccff_tail,
  output logic [ERR_CNT_W-1:0] error_cnt
);

  localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'(BITSTREAM_SIZE);

  logic in_window;
  logic expected;
  logic sample_valid;
  logic sample_miss;

  // Expected tail value for the cycle after enable pulse k: 1 at k=N, 0 at N+1 and N+2.
  always_comb begin
    in_window = 1'b0;
    expected  = 1'b0;
    if (check_en) begin
      if (pulse_idx == FIRST_IDX) begin
        in_window = 1'b1;
        expected  = 1'b1;
      end else if ((pulse_idx == FIRST_IDX + CNT_W'(1)) ||
                   (pulse_idx == FIRST_IDX + CNT_W'(2))) begin
        in_window = 1'b1;
      end
    end
  end

  // Register each tail sample, then fold a mismatch into the saturating count a cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sample_valid <= 1'b0;
      sample_miss  <= 1'b0;
      error_cnt    <= '0;
    end else begin
      sample_valid <= in_window;
      sample_miss  <= (ccff_tail !== expected);
      if (sample_valid && sample_miss && (error_cnt != '1)) begin
        error_cnt <= error_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Transmit end of the configuration chain: serializes bitstream words onto
// ccff_head MSB first with a per-bit prog_clk enable, or runs a single-pulse
// chain integrity test.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int BITSTREAM_SIZE = 1024,
  parameter int WORD_WIDTH     = 32,
  parameter int CNT_W          = $clog2(BITSTREAM_SIZE + 4)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  test_mode,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ccff_head,
  output logic                  prog_clk_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ERR_CNT_W-1:0]  error_cnt
);

  localparam int NUM_WORDS = (BITSTREAM_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WC_W      = $clog2(NUM_WORDS + 1);
  localparam int BL_W      = $clog2(WORD_WIDTH + 1);
  localparam int LAST_BITS = last_word_bits(BITSTREAM_SIZE, WORD_WIDTH);

  localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(BITSTREAM_SIZE - 1);
  localparam logic [CNT_W-1:0] TEST_LAST = CNT_W'(BITSTREAM_SIZE + TEST_EXTRA_SHIFTS - 1);

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] sreg, sreg_nxt;
  logic [BL_W-1:0]       bits_left, bits_left_nxt;
  logic [WC_W-1:0]       word_cnt, word_cnt_nxt;
  logic [CNT_W-1:0]      shift_cnt, shift_cnt_nxt;
  logic                  head_nxt;
  logic                  en_nxt;
  logic                  start_ok;
  logic                  last_word;
  logic                  all_loaded;

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign last_word  = (word_cnt == WC_W'(NUM_WORDS - 1));
  assign all_loaded = (word_cnt == WC_W'(NUM_WORDS));
  assign word_ready = (state == PROG) && (bits_left == '0) && !all_loaded;
  assign busy       = (state == PROG) || (state == TEST) || (state == CHECK);
  assign done       = (state == DONE);
  assign error      = done && (error_cnt != '0);

  // Next-state, serializer and shift-count logic; head/enable are computed here and registered below.
  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    bits_left_nxt = bits_left;
    word_cnt_nxt  = word_cnt;
    shift_cnt_nxt = shift_cnt;
    head_nxt      = ccff_head;
    en_nxt        = 1'b0;
    if (prog_clk_en) begin
      shift_cnt_nxt = shift_cnt + CNT_W'(1);
    end
    case (state)
      IDLE, DONE: begin
        head_nxt = 1'b0;
        if (start) begin
          state_nxt     = test_mode ? TEST : PROG;
          sreg_nxt      = '0;
          bits_left_nxt = '0;
          word_cnt_nxt  = '0;
          shift_cnt_nxt = '0;
          head_nxt      = test_mode;
          en_nxt        = test_mode;
        end
      end
      PROG: begin
        if (prog_clk_en && (shift_cnt == PROG_LAST)) begin
          state_nxt = DONE;
          head_nxt  = 1'b0;
        end else if (bits_left != '0) begin
          head_nxt      = sreg[WORD_WIDTH-1];
          sreg_nxt      = sreg << 1;
          bits_left_nxt = bits_left - BL_W'(1);
          en_nxt        = 1'b1;
        end else if (word_valid && word_ready) begin
          head_nxt      = word_data[WORD_WIDTH-1];
          sreg_nxt      = word_data << 1;
          bits_left_nxt = last_word ? BL_W'(LAST_BITS - 1) : BL_W'(WORD_WIDTH - 1);
          word_cnt_nxt  = word_cnt + WC_W'(1);
          en_nxt        = 1'b1;
        end
      end
      TEST: begin
        head_nxt = 1'b0;
        if (shift_cnt == TEST_LAST) begin
          state_nxt = CHECK;
        end else begin
          en_nxt = 1'b1;
        end
      end
      CHECK: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state       <= IDLE;
      sreg        <= '0;
      bits_left   <= '0;
      word_cnt    <= '0;
      shift_cnt   <= '0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
    end else begin
      state       <= state_nxt;
      sreg        <= sreg_nxt;
      bits_left   <= bits_left_nxt;
      word_cnt    <= word_cnt_nxt;
      shift_cnt   <= shift_cnt_nxt;
      ccff_head   <= head_nxt;
      prog_clk_en <= en_nxt;
    end
  end

  ccff_tail_checker #(
    .BITSTREAM_SIZE (BITSTREAM_SIZE),
    .CNT_W          (CNT_W)
  ) u_tail_checker (
    .clk       (prog_clk),
    .rst_n     (pReset),
    .clear     (start_ok),
    .check_en  (state == TEST),
    .pulse_idx (shift_cnt),
    .ccff_tail (ccff_tail),
    .error_cnt (error_cnt)
  );

endmodule
